// File: rtl/keyboard_spi_pkg.sv
// keyboard_spi_pkg: constants and types shared by the keyboard SPI frame transmitter and receiver
package keyboard_spi_pkg;
   localparam logic [31:0] SYNC_WORD_DEFAULT = 32'h0000_FFFF;
   localparam int FRAME_BITS = 160;
   localparam int WORD_BITS = 32;
   localparam int WAVEFORM_LSB = 0;
   localparam int NOTES_LSB = 2;
   typedef enum logic [1:0] {WF_SQUARE, WF_SAW, WF_TRI, WF_SINE} waveform_t;
   typedef enum logic {IDLE, SHIFT} tx_state_t;
   function automatic logic [WORD_BITS-1:0] ctrl_word(input logic [1:0] notes, input logic [1:0] waveform);
      ctrl_word = '0;
      ctrl_word[WAVEFORM_LSB +: 2] = waveform;
      ctrl_word[NOTES_LSB +: 2] = notes;
   endfunction
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: sck phase divider with end-of-bit strobes, held idle when not enabled
module spi_clk_gen #(
   parameter int HALF_PERIOD = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic sck,
   output logic fall_tick,
   output logic bit_end
);
   localparam int DW = $clog2(HALF_PERIOD) + 1;
   logic [DW-1:0] div;
   logic phase_end;
   assign phase_end = div == DW'(HALF_PERIOD - 1);
   assign bit_end = en && sck && phase_end;
   assign fall_tick = bit_end;
   always_ff @(posedge clk) begin
      if (reset || !en) begin
         div <= '0;
         sck <= 1'b0;
      end else begin
         div <= phase_end ? '0 : div + 1'b1;
         sck <= sck ^ phase_end;
      end
   end
endmodule

// File: rtl/spi_frame_master_tx.sv
// spi_frame_master_tx: latches a 160-bit note/waveform frame on valid&ready and shifts it out MSB first
module spi_frame_master_tx
   import keyboard_spi_pkg::*;
#(
   parameter int HALF_PERIOD = 8,
   parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   output logic        ready,
   input  logic [31:0] prd1,
   input  logic [31:0] prd2,
   input  logic [31:0] prd3,
   input  logic [1:0]  waveform,
   input  logic [1:0]  notes,
   output logic        sck,
   output logic        sdi,
   output logic        done
);
   tx_state_t state, state_next;
   logic [FRAME_BITS-1:0] sr;
   logic [7:0] bit_cnt;
   logic fall_tick, bit_end, accept, last;
   spi_clk_gen #(.HALF_PERIOD(HALF_PERIOD)) u_clk_gen (
      .clk(clk),
      .reset(reset),
      .en(state == SHIFT),
      .sck(sck),
      .fall_tick(fall_tick),
      .bit_end(bit_end)
   );
   assign ready = state == IDLE;
   assign accept = ready && valid;
   assign last = bit_end && bit_cnt == 8'd0;
   // the final shift empties the register, so sdi returns low in IDLE without gating
   assign sdi = sr[FRAME_BITS-1];
   always_comb state_next = accept ? SHIFT : last ? IDLE : state;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sr <= '0;
         bit_cnt <= '0;
         done <= 1'b0;
      end else begin
         state <= state_next;
         done <= last;
         sr <= accept ? {SYNC_WORD, prd1, prd2, prd3, ctrl_word(notes, waveform)}
             : fall_tick ? {sr[FRAME_BITS-2:0], 1'b0} : sr;
         bit_cnt <= accept ? 8'(FRAME_BITS - 1) : bit_end ? bit_cnt - 8'd1 : bit_cnt;
      end
   end
endmodule
